modular_square_iter_ctrl: RTL and testbench

Parametrised iteration controller for the VDF modular-squaring datapath. It loads a start value and runs a runtime-programmable number of back-to-back squarings through an external `modular_square_alu`, which may be pipelined to ALU_LATENCY stages. It then presents the redundant-form result with a valid/ready handshake. It supports abort and a live progress count, and replaces the fixed-2^30-loop, purely combinational-ALU controller.

---
 rtl/modular_square_pkg.sv | 21 ++
 rtl/modular_square_iter_ctrl_phase_counter.sv | 40 ++++
 rtl/modular_square_iter_ctrl.sv | 133 +++++++++++++
 tb/tb_modular_square_iter_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modular_square_pkg.sv
// Shared definitions for the modular-squaring iteration controller:
// one-hot state encoding, limb type and default datapath dimensions.
package modular_square_pkg;

  localparam int NUM_ELEMENTS_DEFAULT = 62;
  localparam int BIT_LEN_DEFAULT      = 18;
  localparam int WORD_LEN_DEFAULT     = 17;

  localparam logic [2:0] ST_IDLE = 3'b001;
  localparam logic [2:0] ST_RUN  = 3'b010;
  localparam logic [2:0] ST_DONE = 3'b100;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  typedef logic [BIT_LEN_DEFAULT-1:0] limb_t;

endpackage

// File: rtl/modular_square_iter_ctrl_phase_counter.sv
// Phase counter for one ALU iteration: issue strobe on phase 0, complete
// strobe on the last phase; with a single-cycle ALU both fire every cycle.
module iter_phase_counter #(
  parameter int ALU_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic issue,
  output logic complete
);

  localparam int PW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [PW-1:0] LAST = PW'(ALU_LATENCY - 1);

  logic [PW-1:0] phase_reg;
  logic [PW-1:0] phase_next;

  always_comb begin
    phase_next = phase_reg;
    if (clear) begin
      phase_next = '0;
    end else if (run) begin
      phase_next = (phase_reg == LAST) ? '0 : phase_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg <= '0;
    end else begin
      phase_reg <= phase_next;
    end
  end

  assign issue    = run && (phase_reg == '0);
  assign complete = run && (phase_reg == LAST);

endmodule

// File: rtl/modular_square_iter_ctrl.sv
// Iteration controller: loads a start value, runs N squarings through an
// external (possibly pipelined) ALU and hands the result out via valid/ready.
module modular_square_iter_ctrl
  import modular_square_pkg::*;
#(
  parameter int NUM_ELEMENTS = NUM_ELEMENTS_DEFAULT,
  parameter int BIT_LEN      = BIT_LEN_DEFAULT,
  parameter int WORD_LEN     = WORD_LEN_DEFAULT,
  parameter int ALU_LATENCY  = 1,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BIT_LEN-1:0]   A [NUM_ELEMENTS],
  input  logic [CNT_WIDTH-1:0] iterations,
  input  logic                 abort,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] iter_count,
  output logic [BIT_LEN-1:0]   alu_a [NUM_ELEMENTS],
  output logic                 alu_issue,
  input  logic [BIT_LEN-1:0]   alu_ms [NUM_ELEMENTS],
  output logic                 valid,
  input  logic                 ready,
  output logic [BIT_LEN-1:0]   ms [NUM_ELEMENTS]
);

  genvar gi;

  generate
    if (ALU_LATENCY < 1 || WORD_LEN >= BIT_LEN) begin : g_bad_params
      $error("modular_square_iter_ctrl: ALU_LATENCY must be >= 1 and WORD_LEN < BIT_LEN");
    end
  endgenerate

  state_t               state_reg;
  state_t               state_next;
  logic [CNT_WIDTH-1:0] count_reg;
  logic [CNT_WIDTH-1:0] count_next;
  logic [CNT_WIDTH-1:0] count_inc;
  logic [CNT_WIDTH-1:0] target_reg;
  logic [CNT_WIDTH-1:0] target_next;
  logic [BIT_LEN-1:0]   work_reg [NUM_ELEMENTS];
  logic                 accept;
  logic                 load_alu;
  logic                 run;
  logic                 issue;
  logic                 complete;

  assign run       = (state_reg == RUN);
  assign count_inc = count_reg + 1'b1;

  iter_phase_counter #(
    .ALU_LATENCY(ALU_LATENCY)
  ) u_phase (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .run      (run),
    .issue    (issue),
    .complete (complete)
  );

  // abort outranks start in IDLE and ready / the final iteration elsewhere
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    target_next = target_reg;
    accept      = 1'b0;
    load_alu    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          accept      = 1'b1;
          target_next = iterations;
          count_next  = '0;
          state_next  = (iterations == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (complete) begin
          load_alu   = 1'b1;
          count_next = count_inc;
          if (count_inc == target_reg) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (abort || ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      target_reg <= '0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      target_reg <= target_next;
    end
  end

  generate
    for (gi = 0; gi < NUM_ELEMENTS; gi++) begin : g_limb
      always_ff @(posedge clk) begin
        if (rst) begin
          work_reg[gi] <= '0;
        end else if (accept) begin
          work_reg[gi] <= A[gi];
        end else if (load_alu) begin
          work_reg[gi] <= alu_ms[gi];
        end
      end
      assign alu_a[gi] = work_reg[gi];
      assign ms[gi]    = work_reg[gi];
    end
  endgenerate

  assign busy       = (state_reg == RUN) || (state_reg == DONE);
  assign valid      = (state_reg == DONE);
  assign alu_issue  = issue;
  assign iter_count = count_reg;

endmodule

// File: tb/tb_modular_square_iter_ctrl.sv
// Bench for modular_square_iter_ctrl: two instances (ALU latency 1 and 4),
// each driving a mock ALU that adds 1 to every limb.
module tb_modular_square_iter_ctrl;

  localparam int NE = 4;
  localparam int BL = 18;
  localparam int CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i   [2];
  logic          start_i [2];
  logic          abort_i [2];
  logic          ready_i [2];
  logic [CW-1:0] iter_i  [2];
  logic [BL-1:0] a_i     [2][NE];
  logic          busy_o  [2];
  logic          valid_o [2];
  logic          issue_o [2];
  logic [CW-1:0] count_o [2];
  logic [BL-1:0] alu_a_o [2][NE];
  logic [BL-1:0] ms_o    [2][NE];

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_dut
    localparam int L = (gi == 0) ? 1 : 4;
    logic [BL-1:0] alu_ms [NE];

    modular_square_iter_ctrl #(
      .NUM_ELEMENTS(NE), .BIT_LEN(BL), .WORD_LEN(17),
      .ALU_LATENCY(L), .CNT_WIDTH(CW)
    ) u_dut (
      .clk        (clk),
      .rst        (rst_i[gi]),
      .start      (start_i[gi]),
      .A          (a_i[gi]),
      .iterations (iter_i[gi]),
      .abort      (abort_i[gi]),
      .busy       (busy_o[gi]),
      .iter_count (count_o[gi]),
      .alu_a      (alu_a_o[gi]),
      .alu_issue  (issue_o[gi]),
      .alu_ms     (alu_ms),
      .valid      (valid_o[gi]),
      .ready      (ready_i[gi]),
      .ms         (ms_o[gi])
    );

    if (L == 1) begin : g_comb_alu
      always_comb begin
        for (int k = 0; k < NE; k++) alu_ms[k] = alu_a_o[gi][k] + 1'b1;
      end
    end else begin : g_pipe_alu
      logic [BL-1:0] pipe [L-1][NE];
      always_ff @(posedge clk) begin
        for (int k = 0; k < NE; k++) begin
          pipe[0][k] <= alu_a_o[gi][k] + 1'b1;
          for (int s = 1; s < L - 1; s++) pipe[s][k] <= pipe[s-1][k];
        end
      end
      always_comb begin
        for (int k = 0; k < NE; k++) alu_ms[k] = pipe[L-2][k];
      end
    end
  end

  // Issue-pulse counter and alu_a stability monitor, sampled mid-cycle
  int issue_total    [2] = '{0, 0};
  int unstable_total [2] = '{0, 0};
  logic [BL-1:0] prev_a [2][NE];
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (issue_o[d]) issue_total[d]++;
      if (busy_o[d] && !valid_o[d] && !issue_o[d]) begin
        for (int k = 0; k < NE; k++)
          if (alu_a_o[d][k] !== prev_a[d][k]) unstable_total[d]++;
      end
      for (int k = 0; k < NE; k++) prev_a[d][k] = alu_a_o[d][k];
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic launch(input int d, input logic [BL-1:0] a0, input logic [BL-1:0] ar,
                        input logic [CW-1:0] n);
    a_i[d][0] = a0;
    for (int k = 1; k < NE; k++) a_i[d][k] = ar;
    iter_i[d]  = n;
    start_i[d] = 1'b1;
    @(posedge clk); #1;
    start_i[d] = 1'b0;
  endtask

  task automatic wait_valid(input int d, input int budget, output int k);
    k = 0;
    while (!valid_o[d] && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic wait_count(input int d, input logic [CW-1:0] target, input int budget);
    int k = 0;
    while (count_o[d] !== target && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  typedef struct {
    int            d;
    logic [BL-1:0] a0;
    logic [BL-1:0] ar;
    logic [CW-1:0] n;
    int            exp_k;
    logic [BL-1:0] exp_m0;
    logic [BL-1:0] exp_mr;
    int            exp_issue;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int bad;
    int i0;
    int u0;
    int d;

    //          d  a0         ar   n   k   m0  mr   issues
    vecs[0] = '{0, 5,         5,   0,  0,  5,  5,   0};
    vecs[1] = '{0, 3,         0,   10, 10, 13, 10,  10};
    vecs[2] = '{1, 7,         100, 3,  12, 10, 103, 3};
    vecs[3] = '{0, 18'h3FFFE, 1,   2,  2,  0,  3,   2};
    vecs[4] = '{1, 20,        0,   1,  4,  21, 1,   1};
    vecs[5] = '{1, 9,         9,   0,  0,  9,  9,   0};

    for (int j = 0; j < 2; j++) begin
      rst_i[j] = 1'b1; start_i[j] = 1'b0; abort_i[j] = 1'b0; ready_i[j] = 1'b0;
      iter_i[j] = '0;
      for (int m = 0; m < NE; m++) a_i[j][m] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_i[0] = 1'b0; rst_i[1] = 1'b0;

    for (int j = 0; j < 2; j++) begin
      chk($sformatf("rst%0d_valid", j), valid_o[j], 0);
      chk($sformatf("rst%0d_busy", j),  busy_o[j], 0);
      chk($sformatf("rst%0d_issue", j), issue_o[j], 0);
      chk($sformatf("rst%0d_count", j), count_o[j], 0);
      chk($sformatf("rst%0d_ms0", j),   ms_o[j][0], 0);
    end

    // Table-driven runs with ready held high
    for (int i = 0; i < 6; i++) begin
      d  = vecs[i].d;
      i0 = issue_total[d];
      u0 = unstable_total[d];
      ready_i[d] = 1'b1;
      launch(d, vecs[i].a0, vecs[i].ar, vecs[i].n);
      wait_valid(d, 200, k);
      chk($sformatf("v%0d_latency", i), k, vecs[i].exp_k);
      chk($sformatf("v%0d_ms0", i), ms_o[d][0], vecs[i].exp_m0);
      chk($sformatf("v%0d_ms_last", i), ms_o[d][NE-1], vecs[i].exp_mr);
      chk($sformatf("v%0d_count", i), count_o[d], vecs[i].n);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid_pulse", i), valid_o[d], 0);
      chk($sformatf("v%0d_idle_busy", i), busy_o[d], 0);
      chk($sformatf("v%0d_issues", i), issue_total[d] - i0, vecs[i].exp_issue);
      chk($sformatf("v%0d_alu_a_stable", i), unstable_total[d] - u0, 0);
      $display("vector %0d: dut=%0d N=%0d latency=%0d ms0=%0d", i, d, vecs[i].n, k, ms_o[d][0]);
    end

    // DONE held with ready low; start during the wait is ignored
    ready_i[0] = 1'b0;
    launch(0, 1, 0, 2);
    wait_valid(0, 50, k);
    chk("hold_latency", k, 2);
    bad = 0;
    for (int j = 0; j < 20; j++) begin
      if (j == 5) begin
        a_i[0][0] = 100; iter_i[0] = 5; start_i[0] = 1'b1;
      end else begin
        start_i[0] = 1'b0;
      end
      @(posedge clk); #1;
      if (!valid_o[0] || ms_o[0][0] !== 3 || count_o[0] !== 2) bad++;
    end
    start_i[0] = 1'b0;
    chk("hold_stable", bad, 0);
    ready_i[0] = 1'b1;
    @(posedge clk); #1;
    chk("hold_release_valid", valid_o[0], 0);
    chk("hold_release_busy", busy_o[0], 0);
    chk("hold_release_count", count_o[0], 2);
    $display("hold sequence: ms0=%0d count=%0d", ms_o[0][0], count_o[0]);

    // Abort mid-run at iter_count 37, then a fresh run
    launch(0, 0, 0, 100);
    wait_count(0, 37, 200);
    chk("abort_reach37", count_o[0], 37);
    abort_i[0] = 1'b1;
    @(posedge clk); #1;
    abort_i[0] = 1'b0;
    chk("abort_busy", busy_o[0], 0);
    chk("abort_valid", valid_o[0], 0);
    chk("abort_count", count_o[0], 37);
    chk("abort_ms0", ms_o[0][0], 37);
    bad = 0;
    for (int j = 0; j < 120; j++) begin
      @(posedge clk); #1;
      if (valid_o[0] || busy_o[0]) bad++;
    end
    chk("abort_quiet", bad, 0);
    launch(0, 0, 0, 4);
    wait_valid(0, 50, k);
    chk("rerun_latency", k, 4);
    chk("rerun_ms0", ms_o[0][0], 4);
    chk("rerun_count", count_o[0], 4);
    @(posedge clk); #1;
    $display("abort sequence: rerun count=%0d", count_o[0]);

    // Abort on the final iteration's completing cycle (latency 4)
    ready_i[1] = 1'b1;
    launch(1, 0, 0, 2);
    wait_count(1, 1, 50);
    chk("final_abort_reach1", count_o[1], 1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    abort_i[1] = 1'b1;
    @(posedge clk); #1;
    abort_i[1] = 1'b0;
    chk("final_abort_busy", busy_o[1], 0);
    chk("final_abort_valid", valid_o[1], 0);
    chk("final_abort_count", count_o[1], 1);
    chk("final_abort_ms0", ms_o[1][0], 1);
    $display("final-iteration abort: count=%0d", count_o[1]);

    // abort and ready together in DONE, then abort beats start in IDLE
    ready_i[0] = 1'b0;
    launch(0, 0, 0, 1);
    wait_valid(0, 20, k);
    chk("ar_latency", k, 1);
    abort_i[0] = 1'b1; ready_i[0] = 1'b1;
    @(posedge clk); #1;
    chk("ar_busy", busy_o[0], 0);
    chk("ar_valid", valid_o[0], 0);
    chk("ar_count", count_o[0], 1);
    chk("ar_ms0", ms_o[0][0], 1);
    a_i[0][0] = 50; iter_i[0] = 3; start_i[0] = 1'b1;
    @(posedge clk); #1;
    start_i[0] = 1'b0; abort_i[0] = 1'b0;
    chk("abort_start_busy", busy_o[0], 0);
    @(posedge clk); #1;
    chk("abort_start_busy2", busy_o[0], 0);
    chk("abort_start_ms0", ms_o[0][0], 1);
    $display("abort/ready and abort/start: busy=%0d ms0=%0d", busy_o[0], ms_o[0][0]);

    // Reset in the middle of a run
    launch(1, 0, 0, 50);
    repeat (20) begin
      @(posedge clk); #1;
    end
    chk("midrst_running", busy_o[1], 1);
    rst_i[1] = 1'b1;
    @(posedge clk); #1;
    rst_i[1] = 1'b0;
    chk("midrst_busy", busy_o[1], 0);
    chk("midrst_valid", valid_o[1], 0);
    chk("midrst_issue", issue_o[1], 0);
    chk("midrst_count", count_o[1], 0);
    chk("midrst_ms0", ms_o[1][0], 0);
    chk("midrst_alu_a0", alu_a_o[1][0], 0);
    $display("mid-run reset: count=%0d ms0=%0d", count_o[1], ms_o[1][0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
